// File: rtl/inputcond_if.sv
// Key-conditioner bundle: raw keys in, debounced level / press pulses out.
// w is sampled asynchronously; z, level and any_z change only on Clock; there is no valid/ready.
interface inputcond_if #(
  parameter int N = 4
);
  logic [N-1:0]   w;
  logic [N-1:0]   z;
  logic [N-1:0]   level;
  logic           any_z;
  logic [2*N-1:0] dbg_state;

  modport master (output w, input z, level, any_z, dbg_state);
  modport slave  (input w, output z, level, any_z, dbg_state);
endinterface

// File: rtl/inputcond_array.sv
// N-channel key conditioner: synchroniser, debounce FSM, registered press pulse and level.
// Optional auto-repeat of press pulses while held: define INPUTCOND_AUTOREPEAT_EN.
module inputcond_array #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  inputcond_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CONFIRM_P, PRESSED, CONFIRM_R} state_t;

  localparam int           CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          REL_RAW  = (ACTIVE_LOW != 0);

  if (N < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("inputcond_array: illegal parameter value");
  end

  logic [N-1:0]      pulse;
  logic [N-1:0]      level_d;
  logic [N-1:0][1:0] st_dbg;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   press_d;

    // Flops hold the raw pin value; reset loads the released level so a held key reads as new.
    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) sync_q <= {SYNC_STAGES{REL_RAW}};
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.w[i]};
    end

    assign s = (ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = PRESSED;
              press_d = 1'b1;
            end else begin
              state_d = CONFIRM_P;
              cnt_d   = CW'(1);
            end
          end
        end
        CONFIRM_P: begin
          if (!s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = IDLE;
            end else begin
              state_d = CONFIRM_R;
              cnt_d   = CW'(1);
            end
          end
        end
        CONFIRM_R: begin
          // Bounce back to pressed restores the level without a fresh pulse.
          if (s) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end

    assign level_d[i] = (state_d == PRESSED) || (state_d == CONFIRM_R);
    assign st_dbg[i]  = state_q;

`ifdef INPUTCOND_AUTOREPEAT_EN
    localparam int            RMAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW      = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          rep_q, rep_d;
    logic          fire;

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        rcnt_q <= '0;
        rep_q  <= 1'b0;
      end else begin
        rcnt_q <= rcnt_d;
        rep_q  <= rep_d;
      end
    end

    // rep_q selects the initial delay before the first repeat, then the steady period.
    always_comb begin
      rcnt_d = rcnt_q;
      rep_d  = rep_q;
      fire   = 1'b0;
      if (press_d || state_d == IDLE) begin
        rcnt_d = '0;
        rep_d  = 1'b0;
      end else if (state_q == PRESSED && state_d == PRESSED) begin
        if (rcnt_q == (rep_q ? RP_LAST : RD_LAST)) begin
          fire   = 1'b1;
          rcnt_d = '0;
          rep_d  = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
    end

    assign pulse[i] = press_d | fire;
`else
    assign pulse[i] = press_d;
`endif
  end

  logic [N-1:0] z_q, level_q;
  logic         any_z_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      z_q     <= '0;
      level_q <= '0;
      any_z_q <= 1'b0;
    end else begin
      z_q     <= pulse;
      level_q <= level_d;
      any_z_q <= |pulse;
    end
  end

  assign bus.z         = z_q;
  assign bus.level     = level_q;
  assign bus.any_z     = any_z_q;
  assign bus.dbg_state = st_dbg;

endmodule
